// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: E/D-stage op encoding, unit op codes, latencies, FSM states.
package md_pkg;

  typedef enum logic [3:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMsub  = 4'd5,
    MdMthi  = 4'd6,
    MdMtlo  = 4'd7,
    MdMfhi  = 4'd8,
    MdMflo  = 4'd9
  } md_op_e;

  localparam logic [1:0] UnitMultu = 2'b00;
  localparam logic [1:0] UnitDivu  = 2'b01;
  localparam logic [1:0] UnitMult  = 2'b10;
  localparam logic [1:0] UnitDiv   = 2'b11;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} md_state_e;

endpackage

// File: rtl/md_op_dec.sv
// Combinational decode of a pipeline md op into unit op code, msub flag and class flags.
module md_op_dec
  import md_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [1:0] unit_op_o,
  output logic       msub_o,
  output logic       is_mul_o,
  output logic       is_div_o,
  output logic       is_mthi_o,
  output logic       is_mtlo_o
);

  always_comb begin
    unit_op_o = UnitMultu;
    msub_o    = 1'b0;
    is_mul_o  = 1'b0;
    is_div_o  = 1'b0;
    is_mthi_o = 1'b0;
    is_mtlo_o = 1'b0;
    case (md_op_e'(op_i))
      MdMult:  begin unit_op_o = UnitMult;  is_mul_o = 1'b1; end
      MdMultu: begin unit_op_o = UnitMultu; is_mul_o = 1'b1; end
      MdMsub:  begin unit_op_o = UnitMult;  is_mul_o = 1'b1; msub_o = 1'b1; end
      MdDiv:   begin unit_op_o = UnitDiv;   is_div_o = 1'b1; end
      MdDivu:  begin unit_op_o = UnitDivu;  is_div_o = 1'b1; end
      MdMthi:  is_mthi_o = 1'b1;
      MdMtlo:  is_mtlo_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide issue and occupancy control with D-stage interlock.
// Optional divide-by-zero trap enabled by defining MD_DIV_ZERO_EN.
module md_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic        e_flush,
  input  logic [3:0]  e_mdop,
  input  logic [31:0] e_rt_val,
  input  logic [3:0]  d_mdop,
  output logic        start,
  output logic [1:0]  mdop,
  output logic        ifmsub,
  output logic        regwritemd,
  output logic        mthi,
  output logic        mtlo,
  output logic        stall_d,
  output logic        busy
`ifdef MD_DIV_ZERO_EN
  ,
  output logic        div_zero
`endif
);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] e_unit_op;
  logic       e_msub, e_is_mul, e_is_div, e_is_mthi, e_is_mtlo;
  logic       e_live, issue_ok, issue;

  md_op_dec u_e_dec (
    .op_i      (e_mdop),
    .unit_op_o (e_unit_op),
    .msub_o    (e_msub),
    .is_mul_o  (e_is_mul),
    .is_div_o  (e_is_div),
    .is_mthi_o (e_is_mthi),
    .is_mtlo_o (e_is_mtlo)
  );

  always_comb begin
    e_live   = e_valid & ~e_flush & ~reset;
    issue_ok = e_live & (e_is_mul | e_is_div) & (state_q == StIdle);
`ifdef MD_DIV_ZERO_EN
    div_zero = issue_ok & e_is_div & (e_rt_val == 32'd0);
    issue    = issue_ok & ~div_zero;
`else
    issue    = issue_ok;
`endif
    start      = issue;
    mdop       = issue ? e_unit_op : UnitMultu;
    ifmsub     = issue & e_msub;
    mthi       = e_live & e_is_mthi;
    mtlo       = e_live & e_is_mtlo;
    regwritemd = mthi | mtlo;
    busy       = (state_q != StIdle);
    // A pending HI/LO move must land before D may read or overwrite HI/LO.
    stall_d    = (d_mdop != 4'(MdNone)) &
                 (busy | start | (e_valid & ~e_flush & (e_is_mthi | e_is_mtlo)));
  end

`ifndef MD_DIV_ZERO_EN
  logic unused_rt_val;
  assign unused_rt_val = ^e_rt_val;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = e_is_mul ? StMul : StDiv;
          cnt_d   = e_is_mul ? 4'(MUL_LAT - 1) : 4'(DIV_LAT - 1);
        end
      end
      StMul, StDiv: begin
        if (cnt_q == 4'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ops arriving while occupied are dropped; D-stage interlock should prevent them.
  a_no_issue_when_busy: assert property (@(posedge clk) disable iff (reset)
    !(e_valid && !e_flush && (e_is_mul || e_is_div) && state_q != StIdle));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: vector table, corner sequences, random vs occupancy model.
module tb_md_ctrl;
  import md_pkg::*;

`ifdef MD_DIV_ZERO_EN
  localparam bit DzEn = 1'b1;
`else
  localparam bit DzEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, e_valid, e_flush;
  logic [3:0]  e_mdop, d_mdop;
  logic [31:0] e_rt_val;
  logic        start, ifmsub, regwritemd, mthi, mtlo, stall_d, busy;
  logic [1:0]  mdop;
`ifdef MD_DIV_ZERO_EN
  logic        div_zero;
`endif

  always #5 clk = ~clk;

  md_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .e_valid    (e_valid),
    .e_flush    (e_flush),
    .e_mdop     (e_mdop),
    .e_rt_val   (e_rt_val),
    .d_mdop     (d_mdop),
    .start      (start),
    .mdop       (mdop),
    .ifmsub     (ifmsub),
    .regwritemd (regwritemd),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .stall_d    (stall_d),
    .busy       (busy)
`ifdef MD_DIV_ZERO_EN
    ,
    .div_zero   (div_zero)
`endif
  );

  typedef struct {
    bit        rst, val, fl;
    bit [3:0]  eop;
    bit [31:0] rt;
    bit [3:0]  dop;
    bit        x_start;
    bit [1:0]  x_mdop;
    bit        x_ifmsub, x_rw, x_mthi, x_mtlo, x_busy, x_stall, x_dz;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit val, bit fl, md_op_e eop, bit [31:0] rt, md_op_e dop,
                              bit st, bit [1:0] md, bit ifm, bit rw, bit mh, bit ml,
                              bit bz, bit stl);
    vec_t v;
    v.rst = rst; v.val = val; v.fl = fl; v.eop = eop; v.rt = rt; v.dop = dop;
    v.x_start = st; v.x_mdop = md; v.x_ifmsub = ifm; v.x_rw = rw; v.x_mthi = mh;
    v.x_mtlo = ml; v.x_busy = bz; v.x_stall = stl; v.x_dz = 1'b0;
    return v;
  endfunction

  task automatic chk(input string tag, input string sig, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h (t=%0t)", tag, sig, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, compare before the rising edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; e_valid = v.val; e_flush = v.fl; e_mdop = v.eop;
    e_rt_val = v.rt; d_mdop = v.dop;
    #2;
    chk(tag, "start", 32'(start), 32'(v.x_start));
    if (v.x_start) begin
      chk(tag, "mdop", 32'(mdop), 32'(v.x_mdop));
      chk(tag, "ifmsub", 32'(ifmsub), 32'(v.x_ifmsub));
    end
    chk(tag, "regwritemd", 32'(regwritemd), 32'(v.x_rw));
    chk(tag, "mthi", 32'(mthi), 32'(v.x_mthi));
    chk(tag, "mtlo", 32'(mtlo), 32'(v.x_mtlo));
    chk(tag, "busy", 32'(busy), 32'(v.x_busy));
    chk(tag, "stall_d", 32'(stall_d), 32'(v.x_stall));
`ifdef MD_DIV_ZERO_EN
    chk(tag, "div_zero", 32'(div_zero), 32'(v.x_dz));
`endif
  endtask

  // Reference model: 'rem' counts the occupied cycles still owed by the unit.
  int rem = 0;

  function automatic vec_t model(bit rst, bit val, bit fl, bit [3:0] eop, bit [31:0] rt,
                                 bit [3:0] dop);
    vec_t v;
    bit live, is_mul, is_div, is_mt, want;
    v.rst = rst; v.val = val; v.fl = fl; v.eop = eop; v.rt = rt; v.dop = dop;
    live   = val && !fl;
    is_mul = (eop == MdMult) || (eop == MdMultu) || (eop == MdMsub);
    is_div = (eop == MdDiv) || (eop == MdDivu);
    is_mt  = (eop == MdMthi) || (eop == MdMtlo);
    want   = !rst && live && (is_mul || is_div) && rem == 0;
    v.x_dz     = want && is_div && rt == 0 && DzEn;
    v.x_start  = want && !v.x_dz;
    case (eop)
      MdMultu: v.x_mdop = 2'b00;
      MdDivu:  v.x_mdop = 2'b01;
      MdDiv:   v.x_mdop = 2'b11;
      default: v.x_mdop = 2'b10;
    endcase
    v.x_ifmsub = (eop == MdMsub);
    v.x_rw     = !rst && live && is_mt;
    v.x_mthi   = v.x_rw && eop == MdMthi;
    v.x_mtlo   = v.x_rw && eop == MdMtlo;
    v.x_busy   = rem > 0;
    v.x_stall  = dop != MdNone && (v.x_busy || v.x_start || (live && is_mt));
    return v;
  endfunction

  function automatic void model_step(vec_t v);
    if (v.rst)              rem = 0;
    else if (rem > 0)       rem = rem - 1;
    else if (v.x_start)     rem = (v.eop == MdDiv || v.eop == MdDivu) ? DIV_LAT : MUL_LAT;
  endfunction

  initial begin
    vec_t v;
    reset = 1'b1; e_valid = 1'b0; e_flush = 1'b0; e_mdop = 4'd0; e_rt_val = 32'd0;
    d_mdop = 4'd0;
    repeat (2) @(negedge clk);

    // Vector table: single multiply, HI/LO moves, flush, msub/multu, div.
    tbl.push_back(mk(0,0,0,MdNone,0,MdMflo, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,0,MdMult,0,MdNone, 1,2'b10,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,MdNone,0,MdNone, 0,0,0,0,0,0, 1,0));
    tbl.push_back(mk(0,0,0,MdNone,0,MdMfhi, 0,0,0,0,0,0, 1,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,MdNone,0,MdNone, 0,0,0,0,0,0, 1,0));
    tbl.push_back(mk(0,1,1,MdMult,0,MdMflo, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,MdMult,0,MdNone, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,MdMthi,0,MdMfhi, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,0,MdMthi,0,MdMfhi, 0,0,0,1,1,0, 0,1));
    tbl.push_back(mk(0,1,0,MdMtlo,0,MdNone, 0,0,0,1,0,1, 0,0));
    tbl.push_back(mk(0,1,0,MdMfhi,0,MdNone, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,0,MdMsub,0,MdNone, 1,2'b10,1,0,0,0, 0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,MdNone,0,MdNone, 0,0,0,0,0,0, 1,0));
    tbl.push_back(mk(0,1,0,MdMultu,0,MdMfhi, 1,2'b00,0,0,0,0, 0,1));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,MdNone,0,MdMfhi, 0,0,0,0,0,0, 1,1));
    tbl.push_back(mk(0,1,0,MdDiv,7,MdNone, 1,2'b11,0,0,0,0, 0,0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0,0,0,MdNone,0,MdNone, 0,0,0,0,0,0, 1,0));
    v = mk(0,1,0,MdNone,0,MdNone, 0,0,0,0,0,0, 0,0);
    v.eop = 4'hF;
    tbl.push_back(v);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // DIVU while D holds MFLO: interlock from the issue cycle through the last busy cycle.
    for (int i = 0; i < 12; i++) begin
      v = mk(0, i == 0, 0, (i == 0) ? MdDivu : MdNone, 3, MdMflo,
             i == 0, 2'b01, 0, 0, 0, 0, i >= 1 && i <= 10, i <= 10);
      apply(v, $sformatf("divu_stall%0d", i));
    end

    // DIV interrupted by reset four cycles in.
    for (int i = 0; i < 6; i++) begin
      v = mk(i == 4, i == 0, 0, (i == 0) ? MdDiv : MdNone, 5, MdMflo,
             i == 0, 2'b11, 0, 0, 0, 0, i >= 1 && i <= 4, i <= 4);
      apply(v, $sformatf("div_reset%0d", i));
    end

    // Divide by zero: trapped when the feature is built in, otherwise issued normally.
    for (int i = 0; i < 12; i++) begin
      v = mk(0, i == 0, 0, (i == 0) ? MdDiv : MdNone, 0, MdNone,
             !DzEn && i == 0, 2'b11, 0, 0, 0, 0, !DzEn && i >= 1 && i <= 10, 0);
      v.x_dz = DzEn && i == 0;
      apply(v, $sformatf("divzero%0d", i));
    end

    // Random traffic against the occupancy model, starting from a reset cycle.
    rem = 0;
    for (int n = 0; n < 600; n++) begin
      bit rst, val, fl;
      bit [3:0] eop, dop;
      bit [31:0] rt;
      rst = (n == 0) || ($urandom_range(0, 39) == 0);
      val = $urandom_range(0, 3) != 0;
      fl  = $urandom_range(0, 5) == 0;
      eop = 4'($urandom_range(0, 11));
      dop = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
      rt  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (!rst && rem > 0 && val && !fl && eop >= 4'd1 && eop <= 4'd5) val = 1'b0;
      v = model(rst, val, fl, eop, rt, dop);
      apply(v, $sformatf("rnd%0d", n));
      model_step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
